// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Purpose:
//   Debounces a raw asynchronous input. The input passes through a two-flop
//   synchronizer. A four-state FSM then accepts a new level only after it has
//   held for STABLE_CYCLES consecutive synchronized samples. When the level is
//   accepted, the FSM emits a one-cycle rise or fall pulse.
//
// Parameters:
//   STABLE_CYCLES  consecutive samples a new level must hold (2..255)
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-high reset
//   d      in   raw, possibly bouncing input
//   q      out  debounced level (registered)
//   rise   out  one-cycle pulse when q goes 0->1 (registered)
//   fall   out  one-cycle pulse when q goes 1->0 (registered)
//   busy   out  high while a candidate level change is being qualified
// -----------------------------------------------------------------------------
module input_debouncer #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      StStableLo,
      StWaitHi,
      StStableHi,
      StWaitLo
   } state_e;

   logic            r_s1;
   logic            r_s2;
   state_e          r_state;
   state_e          w_state_next;
   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_next;
   logic            r_q;
   logic            w_q_next;
   logic            r_rise;
   logic            w_rise_next;
   logic            r_fall;
   logic            w_fall_next;
   logic            r_busy;
   logic            w_busy_next;

   // Two-flop synchronizer; only r_s2 feeds the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= d;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StStableLo;
         r_cnt   <= '0;
         r_q     <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_q     <= w_q_next;
         r_rise  <= w_rise_next;
         r_fall  <= w_fall_next;
         r_busy  <= w_busy_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_q_next     = r_q;
      w_rise_next  = 1'b0;
      w_fall_next  = 1'b0;

      unique case (r_state)
         StStableLo: begin
            if (r_s2) begin
               w_state_next = StWaitHi;
               w_cnt_next   = '0;
            end
         end
         StWaitHi: begin
            // Abort is checked first so a bounce always wins over terminal count.
            if (!r_s2) begin
               w_state_next = StStableLo;
               w_cnt_next   = '0;
            end else if (r_cnt == CntLast) begin
               w_state_next = StStableHi;
               w_cnt_next   = '0;
               w_q_next     = 1'b1;
               w_rise_next  = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         StStableHi: begin
            if (!r_s2) begin
               w_state_next = StWaitLo;
               w_cnt_next   = '0;
            end
         end
         StWaitLo: begin
            if (r_s2) begin
               w_state_next = StStableHi;
               w_cnt_next   = '0;
            end else if (r_cnt == CntLast) begin
               w_state_next = StStableLo;
               w_cnt_next   = '0;
               w_q_next     = 1'b0;
               w_fall_next  = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = StStableLo;
            w_cnt_next   = '0;
         end
      endcase

      // Registered alongside the state so busy tracks the WAIT states cycle-for-cycle.
      w_busy_next = (w_state_next == StWaitHi) || (w_state_next == StWaitLo);
   end

   assign q    = r_q;
   assign rise = r_rise;
   assign fall = r_fall;
   assign busy = r_busy;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Purpose:
//   Directed testbench for input_debouncer with STABLE_CYCLES=4 and a clk
//   period of 10. Edge k is the first rising edge that samples the new d
//   level. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

   logic clk;
   logic reset;
   logic d;
   logic q;
   logic rise;
   logic fall;
   logic busy;

   int errors;
   int checks;

   input_debouncer #(
      .STABLE_CYCLES(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .d    (d),
      .q    (q),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      d     = 1'b0;
      #3;
      checks++;
      if ({q, rise, fall, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_hold: q/rise/fall/busy=%b expected 0000", {q, rise, fall, busy});
      end
      #17;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({q, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle[%0d]: q/rise/fall/busy=%b expected 0000", i,
                     {q, rise, fall, busy});
         end
      end
   endtask

   // Outputs after edges k..k+7 for a held level change.
   task automatic test_rise();
      @(negedge clk);
      d = 1'b1;
      for (int i = 0; i <= 7; i++) begin
         tick();
         checks++;
         if (busy !== ((i >= 2) && (i <= 5))) begin
            errors++;
            $display("FAIL rise_busy[k+%0d]: busy=%b expected %b", i, busy, (i >= 2) && (i <= 5));
         end
         checks++;
         if (q !== (i >= 6) || rise !== (i == 6) || fall !== 1'b0) begin
            errors++;
            $display("FAIL rise_out[k+%0d]: q/rise/fall=%b%b%b expected %b%b0", i, q, rise, fall,
                     i >= 6, i == 6);
         end
      end
   endtask

   task automatic test_fall();
      @(negedge clk);
      d = 1'b0;
      for (int i = 0; i <= 7; i++) begin
         tick();
         checks++;
         if (busy !== ((i >= 2) && (i <= 5))) begin
            errors++;
            $display("FAIL fall_busy[k+%0d]: busy=%b expected %b", i, busy, (i >= 2) && (i <= 5));
         end
         checks++;
         if (q !== (i < 6) || fall !== (i == 6) || rise !== 1'b0) begin
            errors++;
            $display("FAIL fall_out[k+%0d]: q/rise/fall=%b%b%b expected %b0%b", i, q, rise, fall,
                     i < 6, i == 6);
         end
      end
   endtask

   // d pattern per edge: 1,1,0,1,1 then 0 for the rest.
   task automatic test_bounce();
      logic [4:0] pat;
      int         busy_seen;
      int         rise_seen;
      int         q_seen;
      pat       = 5'b11011;
      busy_seen = 0;
      rise_seen = 0;
      q_seen    = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         d = (i < 5) ? pat[4-i] : 1'b0;
         tick();
         if (busy) busy_seen++;
         if (rise) rise_seen++;
         if (q) q_seen++;
      end
      checks++;
      if (rise_seen != 0 || q_seen != 0) begin
         errors++;
         $display("FAIL bounce_noaccept: rise_cycles=%0d q_cycles=%0d expected 0 0", rise_seen,
                  q_seen);
      end
      checks++;
      if (busy_seen == 0) begin
         errors++;
         $display("FAIL bounce_busy: busy_cycles=%0d expected nonzero", busy_seen);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bounce_settle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_glitch();
      logic s1_before;
      tick();
      s1_before = dut.r_s1;
      #2;
      d = 1'b1;
      #3;
      d = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (dut.r_s1 !== s1_before || {q, rise, busy} !== 3'b000) begin
            errors++;
            $display("FAIL glitch[%0d]: s1=%b q/rise/busy=%b expected s1=%b 000", i, dut.r_s1,
                     {q, rise, busy}, s1_before);
         end
      end
   endtask

   task automatic test_reset_mid();
      int rise_cnt;
      @(negedge clk);
      d = 1'b1;
      for (int i = 0; i <= 4; i++) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: busy=%b expected 1", busy);
      end
      #4;
      reset = 1'b1;
      #1;
      checks++;
      if (q !== 1'b0 || busy !== 1'b0 || rise !== 1'b0 || dut.r_cnt !== '0) begin
         errors++;
         $display("FAIL midrst_async: q=%b busy=%b rise=%b cnt=%0d expected 0 0 0 0", q, busy,
                  rise, dut.r_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({q, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_hold[%0d]: q/rise/fall/busy=%b expected 0000", i,
                     {q, rise, fall, busy});
         end
      end
      @(negedge clk);
      reset    = 1'b0;
      rise_cnt = 0;
      // i=0 is the first edge with reset low.
      for (int i = 0; i < 14; i++) begin
         tick();
         if (rise) rise_cnt++;
         checks++;
         if (rise !== (i == 6) || q !== (i >= 6)) begin
            errors++;
            $display("FAIL midrst_release[+%0d]: q/rise=%b%b expected %b%b", i, q, rise, i >= 6,
                     i == 6);
         end
      end
      checks++;
      if (rise_cnt != 1) begin
         errors++;
         $display("FAIL midrst_rise_once: rise pulses=%0d expected 1", rise_cnt);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      d      = 1'b0;
      test_reset();
      test_rise();
      test_fall();
      test_bounce();
      test_glitch();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive synchronized samples a new level must hold before it is accepted (legal range 2..255).
REQ-002 The module SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The module SHALL have port d  input  1  raw, asynchronous, possibly bouncing input.
REQ-005 The module SHALL have port q  output  1  debounced level, registered.
REQ-006 The module SHALL have port rise  output  1  one-cycle pulse when q goes 0->1, registered.
REQ-007 The module SHALL have port fall  output  1  one-cycle pulse when q goes 1->0, registered.
REQ-008 The module SHALL have port busy  output  1  high while a candidate level change is being qualified.
REQ-009 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-010 d SHALL pass through a two-flop synchronizer (s1 <= d, s2 <= s1); only s2 feeds the rest of the logic.
REQ-011 The controller SHALL be an FSM with four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-012 STABLE_LO: s2=1 -> WAIT_HI with cnt <= 0; otherwise hold.
REQ-013 WAIT_HI: s2=0 -> STABLE_LO (bounce abort, cnt <= 0, no pulse); s2=1 and cnt=STABLE_CYCLES-1 -> STABLE_HI, q <= 1, rise <= 1; otherwise cnt <= cnt+1.
REQ-014 STABLE_HI: s2=0 -> WAIT_LO with cnt <= 0; otherwise hold.
REQ-015 WAIT_LO: s2=1 -> STABLE_HI (abort, cnt <= 0, no pulse); s2=0 and cnt=STABLE_CYCLES-1 -> STABLE_LO, q <= 0, fall <= 1; otherwise cnt <= cnt+1.
REQ-016 cnt SHALL be ceil(log2(STABLE_CYCLES)) bits wide and SHALL never exceed STABLE_CYCLES-1 (no wrap-around).
REQ-017 rise and fall SHALL be high for exactly one clk cycle, coincident with the cycle in which q first shows the new value; both SHALL be 0 in every other cycle and never high together.
REQ-018 busy SHALL be a registered copy of (state = WAIT_HI or WAIT_LO).
REQ-019 Latency: if d is first sampled high at edge k and sampled high at edges k..k+STABLE_CYCLES, q and rise SHALL go high at edge k+STABLE_CYCLES+2 (edge k+6 for default); falling edges are symmetric.
REQ-020 A level held for fewer than STABLE_CYCLES+1 consecutive samples SHALL NOT change q; a pulse on d entirely between two rising edges SHALL have no effect.
REQ-021 Simultaneous abort and terminal count cannot occur: abort (s2 back at old level) SHALL take priority in any implementation of REQ-013/REQ-015.

Reset
REQ-022 While reset=1, s1, s2, cnt SHALL be 0, state SHALL be STABLE_LO, and q, rise, fall, busy SHALL be 0, taking effect immediately without a clk edge.
REQ-023 Reset asserted mid-qualification SHALL discard the candidate with no rise/fall pulse; after release, qualification restarts from STABLE_LO per REQ-019.
REQ-024 Reset deassertion with d=1 held SHALL produce rise exactly once, STABLE_CYCLES+2 edges after the first edge at which reset is low.

Verification (clk period 10, STABLE_CYCLES=4)
REQ-025 reset=1 for 20, d=0, reset=0, run 100 -> q=0, rise=fall=busy=0 throughout.
REQ-026 d=1 before edge k, held -> busy high from edge k+2, q=1 and rise=1 at edge k+6, rise=0 at k+7, busy=0 after k+6.
REQ-027 From q=1, d=0 held -> q=0 and fall=1 at edge k+6, fall=0 at k+7, rise stays 0.
REQ-028 Bounce: d=1 for 2 edges, 0 for 1, 1 for 2, then 0 -> q stays 0, busy pulses, rise never asserted.
REQ-029 d=1 held; reset=1 asserted mid-cycle between edges k+4 and k+5 -> q, busy, cnt 0 immediately; after release with d=1, rise fires once at first-low edge +6.
REQ-030 d glitch 0->1->0 of width 3 time units placed between rising edges -> s1, q, busy, rise all unchanged.
